// File: rtl/wb_arbiter_if.sv
// Bus bundle for the writeback arbiter: the ALU result stream, the memory
// result stream, the register-file write port and the FIFO occupancy.
// "slave" is the arbiter's view, "master" is the producer/consumer side.
interface wb_arbiter_if #(
  parameter int QDEPTH = 4
);
  localparam int CW = $clog2(QDEPTH) + 1;

  // ALU result stream (single-cycle producer)
  logic          alu_valid;
  logic          alu_ready;
  logic [4:0]    alu_idx;
  logic [31:0]   alu_data;

  // Memory/load result stream (variable-latency producer)
  logic          mem_valid;
  logic          mem_ready;
  logic [4:0]    mem_idx;
  logic [31:0]   mem_data;

  // Register-file write port
  logic          wr_en;
  logic [4:0]    wr_idx;
  logic [31:0]   wr_data;

  // Memory-result FIFO occupancy
  logic [CW-1:0] q_count;

  modport slave (
    input  alu_valid, alu_idx, alu_data,
    input  mem_valid, mem_idx, mem_data,
    output alu_ready, mem_ready,
    output wr_en, wr_idx, wr_data,
    output q_count
  );

  modport master (
    output alu_valid, alu_idx, alu_data,
    output mem_valid, mem_idx, mem_data,
    input  alu_ready, mem_ready,
    input  wr_en, wr_idx, wr_data,
    input  q_count
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter for the single register-file write port.
// ALU results win by fixed priority; load results wait in a small circular
// FIFO. A starvation counter forces one FIFO pop after STARVE_MAX
// consecutive ALU wins over a non-empty FIFO. The write port is registered.
module wb_arbiter #(
  parameter int QDEPTH     = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  localparam logic [CW-1:0] DEPTH_C      = CW'(QDEPTH);
  localparam logic [SW-1:0] STARVE_MAX_C = SW'(STARVE_MAX);

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } entry_t;

  // FIFO storage and bookkeeping
  entry_t          fifo_mem [QDEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SW-1:0]   starve_q, starve_d;

  // Registered write port
  logic            wr_en_q, wr_en_d;
  logic [4:0]      wr_idx_q, wr_idx_d;
  logic [31:0]     wr_data_q, wr_data_d;

  // Per-cycle arbitration terms
  entry_t          head_entry;
  logic            empty;
  logic            starved;
  logic            alu_ready;
  logic            mem_ready;
  logic            alu_take;
  logic            pop;
  logic            push;

  assign head_entry = fifo_mem[head_q];

  // Handshake and arbitration decisions, all from registered state
  always_comb begin
    empty     = (count_q == '0);
    // Credit comes only from the registered count; a same-cycle pop does not
    // open a slot, which keeps mem_ready off the pop->ready path.
    mem_ready = (count_q < DEPTH_C);
    starved   = (starve_q == STARVE_MAX_C) && !empty;
    alu_ready = !starved;
    // Writes to register 0 are null: accepted but never occupy the port.
    alu_take  = bus.alu_valid && (bus.alu_idx != 5'd0) && alu_ready;
    pop       = !empty && !alu_take;
    push      = bus.mem_valid && mem_ready && (bus.mem_idx != 5'd0);
  end

  // Next-state for FIFO pointers, occupancy and starvation counter
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // (no latch); blocking '=' is correct inside always_comb.
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    starve_d = starve_q;

    if (pop)  head_d = head_q + PW'(1);
    if (push) tail_d = tail_q + PW'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (pop || empty) begin
      starve_d = '0;
    end else if (alu_take && (starve_q != STARVE_MAX_C)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Next value of the registered write port
  always_comb begin
    wr_en_d   = 1'b0;
    wr_idx_d  = wr_idx_q;
    wr_data_d = wr_data_q;

    if (alu_take) begin
      wr_en_d   = 1'b1;
      wr_idx_d  = bus.alu_idx;
      wr_data_d = bus.alu_data;
    end else if (pop) begin
      wr_en_d   = 1'b1;
      wr_idx_d  = head_entry.idx;
      wr_data_d = head_entry.data;
    end
  end

  // Control state registers; reset drops every queued entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking '<=' so every flop samples
      // the pre-edge values regardless of statement order.
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      wr_en_q   <= wr_en_d;
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
    end
  end

  // FIFO storage write
  // NOTE: the storage array is deliberately not reset; an empty count already
  // masks stale contents, and leaving it unreset lets it map to plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[tail_q] <= '{idx: bus.mem_idx, data: bus.mem_data};
    end
  end

  assign bus.alu_ready = alu_ready;
  assign bus.mem_ready = mem_ready;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_idx    = wr_idx_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.q_count   = count_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios followed by random
// producer traffic, all compared against a queue-based reference model.
module tb_wb_arbiter;

  localparam int QD = 4;
  localparam int SM = 3;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  wb_arbiter_if #(.QDEPTH(QD)) bus ();

  wb_arbiter #(.QDEPTH(QD), .STARVE_MAX(SM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model state
  ent_t        mq[$];
  int          m_starve;
  logic        m_wr_en;
  logic [4:0]  m_wr_idx;
  logic [31:0] m_wr_data;
  bit          alu_acc;
  bit          mem_acc;

  // Scenario statistics
  int n_total = 0;
  int n_bad   = 0;
  int max_q;
  bit saw_mem_block;
  int alu_block_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_starve  = 0;
    m_wr_en   = 1'b0;
    m_wr_idx  = '0;
    m_wr_data = '0;
    alu_acc   = 1'b0;
    mem_acc   = 1'b0;
  endtask

  task automatic drive_idle();
    bus.alu_valid = 1'b0;
    bus.alu_idx   = '0;
    bus.alu_data  = '0;
    bus.mem_valid = 1'b0;
    bus.mem_idx   = '0;
    bus.mem_data  = '0;
  endtask

  task automatic set_alu(input logic [4:0] idx, input logic [31:0] data);
    bus.alu_valid = 1'b1;
    bus.alu_idx   = idx;
    bus.alu_data  = data;
  endtask

  task automatic set_mem(input logic [4:0] idx, input logic [31:0] data);
    bus.mem_valid = 1'b1;
    bus.mem_idx   = idx;
    bus.mem_data  = data;
  endtask

  // One clock cycle: inputs were driven at the preceding negedge. Check the
  // DUT against the model, advance the model by the arbitration rules, then
  // step to the next negedge.
  task automatic tick();
    bit   empty, m_mready, m_aready, take, pop;
    ent_t h;
    #1;
    empty    = (mq.size() == 0);
    m_mready = (mq.size() < QD);
    m_aready = !((m_starve == SM) && !empty);

    chk("alu_ready", 64'(bus.alu_ready), 64'(m_aready));
    chk("mem_ready", 64'(bus.mem_ready), 64'(m_mready));
    chk("q_count",   64'(bus.q_count),   64'(mq.size()));
    chk("wr_en",     64'(bus.wr_en),     64'(m_wr_en));
    chk("wr_idx",    64'(bus.wr_idx),    64'(m_wr_idx));
    chk("wr_data",   64'(bus.wr_data),   64'(m_wr_data));

    if (int'(bus.q_count) > max_q) max_q = int'(bus.q_count);
    if (!bus.mem_ready) saw_mem_block = 1'b1;
    if (!bus.alu_ready) alu_block_cnt++;

    take    = bus.alu_valid && (bus.alu_idx != 0) && m_aready;
    pop     = !empty && !take;
    alu_acc = bus.alu_valid && m_aready;
    mem_acc = bus.mem_valid && m_mready;

    if (take) begin
      m_wr_en   = 1'b1;
      m_wr_idx  = bus.alu_idx;
      m_wr_data = bus.alu_data;
    end else if (pop) begin
      h         = mq.pop_front();
      m_wr_en   = 1'b1;
      m_wr_idx  = h.idx;
      m_wr_data = h.data;
    end else begin
      m_wr_en   = 1'b0;
    end

    if (mem_acc && (bus.mem_idx != 0)) mq.push_back('{idx: bus.mem_idx, data: bus.mem_data});

    if (pop || empty)                  m_starve = 0;
    else if (take && (m_starve < SM)) m_starve++;

    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    drive_idle();
    for (int i = 0; i < n; i++) tick();
  endtask

  // Hard stop in case anything ever blocks
  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int next_mem;
    drive_idle();
    model_reset();
    max_q         = 0;
    saw_mem_block = 1'b0;
    alu_block_cnt = 0;

    // Reset state
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_wr_en",     64'(bus.wr_en),     64'd0);
    chk("rst_wr_idx",    64'(bus.wr_idx),    64'd0);
    chk("rst_wr_data",   64'(bus.wr_data),   64'd0);
    chk("rst_q_count",   64'(bus.q_count),   64'd0);
    chk("rst_mem_ready", 64'(bus.mem_ready), 64'd1);
    chk("rst_alu_ready", 64'(bus.alu_ready), 64'd1);
    rst = 1'b1;
    @(negedge clk);

    // 1. ALU only: written one cycle later
    set_alu(5'd5, 32'hDEADBEEF);
    tick();
    drive_idle();
    chk("t1_wr_en",   64'(bus.wr_en),   64'd1);
    chk("t1_wr_idx",  64'(bus.wr_idx),  64'd5);
    chk("t1_wr_data", 64'(bus.wr_data), 64'hDEADBEEF);
    tick();

    // 2. Idle mem: queued next cycle, written two cycles later
    set_mem(5'd7, 32'h00001234);
    tick();
    drive_idle();
    chk("t2_q_count_n1", 64'(bus.q_count), 64'd1);
    chk("t2_wr_en_n1",   64'(bus.wr_en),   64'd0);
    tick();
    chk("t2_wr_en_n2",   64'(bus.wr_en),   64'd1);
    chk("t2_wr_idx_n2",  64'(bus.wr_idx),  64'd7);
    chk("t2_q_count_n2", 64'(bus.q_count), 64'd0);
    drain(2);

    // 3. Fill: ALU busy every cycle, five mem beats; the fifth must wait
    max_q         = 0;
    saw_mem_block = 1'b0;
    sent          = 0;
    next_mem      = 0;
    for (int c = 0; c < 24; c++) begin
      if (!bus.alu_valid || alu_acc) set_alu(5'(1 + (c % 30)), 32'hA000_0000 + 32'(c));
      if (bus.mem_valid && mem_acc) sent++;
      if (sent >= 5) begin
        bus.mem_valid = 1'b0;
      end else if (!bus.mem_valid || mem_acc) begin
        set_mem(5'(16 + next_mem), 32'hB000_0000 + 32'(next_mem));
        next_mem++;
      end
      tick();
    end
    if (bus.mem_valid && mem_acc) sent++;
    chk("t3_beats_sent",  64'(sent),          64'd5);
    chk("t3_max_q_count", 64'(max_q),         64'd4);
    chk("t3_mem_blocked", 64'(saw_mem_block), 64'd1);
    drain(8);

    // 4. Starvation: one queued entry, ALU valid every cycle
    set_mem(5'd9, 32'h0000_0009);
    tick();
    bus.mem_valid = 1'b0;
    alu_block_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      set_alu(5'(10 + k), 32'hC000_0000 + 32'(k));
      tick();
    end
    set_alu(5'd13, 32'hC000_0013);
    tick();
    chk("t4_forced_idx", 64'(bus.wr_idx), 64'd9);
    tick();
    chk("t4_held_idx",   64'(bus.wr_idx), 64'd13);
    chk("t4_block_cnt",  64'(alu_block_cnt), 64'd1);
    drain(3);

    // 5. Zero index: null ALU beat lets the queued entry through
    set_mem(5'd3, 32'h0000_0333);
    tick();
    bus.mem_valid = 1'b0;
    set_alu(5'd0, 32'hFFFF_FFFF);
    tick();
    bus.alu_valid = 1'b0;
    chk("t5_pop_idx", 64'(bus.wr_idx), 64'd3);
    set_mem(5'd0, 32'h5555_5555);
    tick();
    bus.mem_valid = 1'b0;
    chk("t5_null_q_count", 64'(bus.q_count), 64'd0);
    chk("t5_null_wr_en",   64'(bus.wr_en),   64'd0);
    drain(2);

    // 6. Reset mid-operation with three entries queued
    for (int k = 0; k < 3; k++) begin
      set_alu(5'(20 + k), 32'hD000_0000 + 32'(k));
      set_mem(5'(24 + k), 32'hE000_0000 + 32'(k));
      tick();
    end
    drive_idle();
    chk("t6_q_before_rst", 64'(bus.q_count), 64'd3);
    rst = 1'b0;
    #1;
    chk("t6_rst_wr_en",     64'(bus.wr_en),     64'd0);
    chk("t6_rst_q_count",   64'(bus.q_count),   64'd0);
    chk("t6_rst_mem_ready", 64'(bus.mem_ready), 64'd1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    drain(6);

    // Random producer traffic with hold-while-not-ready behaviour
    for (int c = 0; c < 400; c++) begin
      if (!bus.alu_valid || alu_acc) begin
        bus.alu_valid = ($urandom_range(0, 99) < 60);
        bus.alu_idx   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        bus.alu_data  = $urandom;
      end
      if (!bus.mem_valid || mem_acc) begin
        bus.mem_valid = ($urandom_range(0, 99) < 50);
        bus.mem_idx   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        bus.mem_data  = $urandom;
      end
      tick();
    end
    drain(10);
    chk("final_q_empty", 64'(bus.q_count), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
